// File: rtl/rcb_reg_arb_if.sv
// SPI-slave, local-master and register-bus signals of rcb_reg_arb.
// The arbiter connects through the master modport; the environment uses the slave modport.
interface rcb_reg_arb_if;
  // *_rdy and *_ack are one-cycle pulses that qualify the data beside them.
  // *_req are levels held stable until the matching ack pulse.
  logic [15:0] spi_addr;
  logic        spi_addr_rdy;
  logic        spi_rd;
  logic [31:0] spi_wdata;
  logic        spi_wdata_rdy;
  logic [31:0] spi_rdata;
  logic        loc_req;
  logic        loc_we;
  logic [15:0] loc_addr;
  logic [31:0] loc_wdata;
  logic        loc_ack;
  logic [31:0] loc_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        arb_err;

  modport master (
    input  spi_addr, spi_addr_rdy, spi_rd, spi_wdata, spi_wdata_rdy,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    input  bus_ack, bus_rdata,
    output spi_rdata, loc_ack, loc_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, arb_err
  );

  modport slave (
    output spi_addr, spi_addr_rdy, spi_rd, spi_wdata, spi_wdata_rdy,
    output loc_req, loc_we, loc_addr, loc_wdata,
    output bus_ack, bus_rdata,
    input  spi_rdata, loc_ack, loc_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, arb_err
  );
endinterface

// File: rtl/rcb_reg_arb.sv
// Register-bus arbiter between the SPI slave (read > write) and one local master.
// Optional grant timeout is built in when RCB_ARB_TIMEOUT_EN is defined.
module rcb_reg_arb #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic          clk_100m,
  input  logic          rst_n_syn,
  rcb_reg_arb_if.master rif,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPI_RD = 2'd1,
    SPI_WR = 2'd2,
    LOC    = 2'd3
  } state_t;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("rcb_reg_arb: TIMEOUT_CYC must lie in 2..255");
  end

  state_t      state;
  logic        rd_pend;
  logic        wr_pend;
  logic [15:0] rd_addr_q;
  logic [15:0] wr_addr_q;
  logic [31:0] wr_data_q;

  logic rd_pulse;
  logic wa_pulse;
  logic wr_pulse;
  logic rd_take;
  logic wr_take;
  logic loc_take;
  logic rd_ovr;
  logic wr_ovr;
  logic timeout;

  assign rd_pulse = rif.spi_addr_rdy & rif.spi_rd;
  assign wa_pulse = rif.spi_addr_rdy & ~rif.spi_rd;
  assign wr_pulse = rif.spi_wdata_rdy;

  // A read pulse arriving in the IDLE decision cycle is served directly.
  assign rd_take  = (state == IDLE) & (rd_pend | rd_pulse);
  assign wr_take  = (state == IDLE) & ~rd_take & wr_pend;
  assign loc_take = (state == IDLE) & ~rd_take & ~wr_take & rif.loc_req & ~rif.loc_ack;

  // A write pulse landing as the old write is granted simply becomes the next pending write.
  assign rd_ovr = rd_pulse & rd_pend;
  assign wr_ovr = wr_pulse & wr_pend & ~wr_take;

`ifdef RCB_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign timeout = (state != IDLE) & ~rif.bus_ack & (to_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      to_cnt <= 8'd0;
    end else if (state == IDLE || rif.bus_ack || timeout) begin
      to_cnt <= 8'd0;
    end else begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      rd_addr_q <= 16'h0;
      wr_addr_q <= 16'h0;
      wr_data_q <= 32'h0;
    end else begin
      if (rd_pulse) rd_addr_q <= rif.spi_addr;
      if (wa_pulse) wr_addr_q <= rif.spi_addr;
      if (wr_pulse) wr_data_q <= rif.spi_wdata;
      rd_pend <= (rd_pend | rd_pulse) & ~rd_take;
      wr_pend <= (wr_pend & ~wr_take) | wr_pulse;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      state         <= IDLE;
      rif.bus_req   <= 1'b0;
      rif.bus_we    <= 1'b0;
      rif.bus_addr  <= 16'h0;
      rif.bus_wdata <= 32'h0;
      rif.spi_rdata <= 32'h0;
      rif.loc_rdata <= 32'h0;
      rif.loc_ack   <= 1'b0;
      rif.arb_err   <= 1'b0;
    end else begin
      rif.loc_ack <= 1'b0;
      rif.arb_err <= rd_ovr | wr_ovr | timeout;
      case (state)
        IDLE: begin
          if (rd_take) begin
            state         <= SPI_RD;
            rif.bus_req   <= 1'b1;
            rif.bus_we    <= 1'b0;
            rif.bus_addr  <= rd_pulse ? rif.spi_addr : rd_addr_q;
            rif.bus_wdata <= 32'h0;
          end else if (wr_take) begin
            state         <= SPI_WR;
            rif.bus_req   <= 1'b1;
            rif.bus_we    <= 1'b1;
            rif.bus_addr  <= wr_addr_q;
            rif.bus_wdata <= wr_data_q;
          end else if (loc_take) begin
            state         <= LOC;
            rif.bus_req   <= 1'b1;
            rif.bus_we    <= rif.loc_we;
            rif.bus_addr  <= rif.loc_addr;
            rif.bus_wdata <= rif.loc_we ? rif.loc_wdata : 32'h0;
          end
        end
        default: begin
          // Completion or abort returns to IDLE, which guarantees one idle cycle between grants.
          if (rif.bus_ack || timeout) begin
            state         <= IDLE;
            rif.bus_req   <= 1'b0;
            rif.bus_we    <= 1'b0;
            rif.bus_addr  <= 16'h0;
            rif.bus_wdata <= 32'h0;
            if (state == SPI_RD) begin
              rif.spi_rdata <= rif.bus_ack ? rif.bus_rdata : ERR_DATA;
            end
            if (state == LOC) begin
              rif.loc_ack <= 1'b1;
              if (!rif.bus_ack) begin
                rif.loc_rdata <= ERR_DATA;
              end else if (!rif.bus_we) begin
                rif.loc_rdata <= rif.bus_rdata;
              end
            end
          end
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rcb_reg_arb.sv
// Bench for rcb_reg_arb: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_rcb_reg_arb;

  localparam int          TIMEOUT_CYC = 16;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
`ifdef RCB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int K_RD = 1;
  localparam int K_WR = 2;
  localparam int K_LC = 3;

  logic       clk_100m  = 1'b0;
  logic       rst_n_syn = 1'b0;
  logic [1:0] dbg_state;

  rcb_reg_arb_if rif ();

  rcb_reg_arb #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .ERR_DATA   (ERR_DATA)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n_syn(rst_n_syn),
    .rif      (rif.master),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_100m = ~clk_100m;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One record for the transaction on the bus, plus the SPI requests still waiting.
  typedef struct {
    bit          active;
    int          kind;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          age;
  } grant_t;

  grant_t      g;
  bit          m_rd_pend;
  logic [15:0] m_rd_addr;
  bit          m_wr_pend;
  logic [15:0] m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] e_spi_rdata;
  logic [31:0] e_loc_rdata;
  bit          e_loc_ack;
  bit          e_arb_err;

  task automatic model_reset();
    g = '{active: 1'b0, kind: 0, we: 1'b0, addr: 16'h0, wdata: 32'h0, age: 0};
    m_rd_pend   = 1'b0;
    m_rd_addr   = 16'h0;
    m_wr_pend   = 1'b0;
    m_wr_addr   = 16'h0;
    m_wr_data   = 32'h0;
    e_spi_rdata = 32'h0;
    e_loc_rdata = 32'h0;
    e_loc_ack   = 1'b0;
    e_arb_err   = 1'b0;
  endtask

  task automatic start_grant(input int kind, input bit we, input logic [15:0] addr,
                             input logic [31:0] wdata);
    g = '{active: 1'b1, kind: kind, we: we, addr: addr, wdata: wdata, age: 0};
  endtask

  task automatic model_step();
    bit rd_new;
    bit wa_new;
    bit wd_new;
    bit err;
    bit ack_next;
    bit took_rd;
    bit took_wr;
    bit to;
    rd_new   = rif.spi_addr_rdy && rif.spi_rd;
    wa_new   = rif.spi_addr_rdy && !rif.spi_rd;
    wd_new   = rif.spi_wdata_rdy;
    err      = 1'b0;
    ack_next = 1'b0;
    took_rd  = 1'b0;
    took_wr  = 1'b0;
    if (g.active) begin
      g.age++;
      to = TO_EN && !rif.bus_ack && (g.age == TIMEOUT_CYC);
      if (rif.bus_ack || to) begin
        if (g.kind == K_RD) e_spi_rdata = rif.bus_ack ? rif.bus_rdata : ERR_DATA;
        if (g.kind == K_LC) begin
          ack_next = 1'b1;
          if (!rif.bus_ack) e_loc_rdata = ERR_DATA;
          else if (!g.we) e_loc_rdata = rif.bus_rdata;
        end
        if (to) err = 1'b1;
        g.active = 1'b0;
      end
    end else if (m_rd_pend || rd_new) begin
      start_grant(K_RD, 1'b0, rd_new ? rif.spi_addr : m_rd_addr, 32'h0);
      took_rd = 1'b1;
    end else if (m_wr_pend) begin
      start_grant(K_WR, 1'b1, m_wr_addr, m_wr_data);
      took_wr = 1'b1;
    end else if (rif.loc_req && !e_loc_ack) begin
      start_grant(K_LC, rif.loc_we, rif.loc_addr, rif.loc_we ? rif.loc_wdata : 32'h0);
    end
    if (rd_new && m_rd_pend) err = 1'b1;
    if (wd_new && m_wr_pend && !took_wr) err = 1'b1;
    m_rd_pend = (m_rd_pend || rd_new) && !took_rd;
    m_wr_pend = (m_wr_pend && !took_wr) || wd_new;
    if (rd_new) m_rd_addr = rif.spi_addr;
    if (wa_new) m_wr_addr = rif.spi_addr;
    if (wd_new) m_wr_data = rif.spi_wdata;
    e_loc_ack = ack_next;
    e_arb_err = err;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_100m or negedge rst_n_syn);
      if (!rst_n_syn) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_100m) begin
    if (chk_en) begin
      check("bus_req",   32'(rif.bus_req),   32'(g.active));
      check("bus_we",    32'(rif.bus_we),    32'(g.active && g.we));
      check("bus_addr",  32'(rif.bus_addr),  g.active ? 32'(g.addr) : 32'h0);
      check("bus_wdata", rif.bus_wdata,      g.active ? g.wdata : 32'h0);
      check("spi_rdata", rif.spi_rdata,      e_spi_rdata);
      check("loc_ack",   32'(rif.loc_ack),   32'(e_loc_ack));
      check("loc_rdata", rif.loc_rdata,      e_loc_rdata);
      check("arb_err",   32'(rif.arb_err),   32'(e_arb_err));
    end
  end

  // ---------------- driver tasks ----------------
  int ack_wait = -1;

  task automatic idle_pulses();
    rif.spi_addr_rdy  = 1'b0;
    rif.spi_wdata_rdy = 1'b0;
    rif.bus_ack       = 1'b0;
  endtask

  task automatic init_inputs();
    idle_pulses();
    rif.spi_addr  = 16'h0;
    rif.spi_rd    = 1'b0;
    rif.spi_wdata = 32'h0;
    rif.loc_req   = 1'b0;
    rif.loc_we    = 1'b0;
    rif.loc_addr  = 16'h0;
    rif.loc_wdata = 32'h0;
    rif.bus_rdata = 32'h0;
  endtask

  task automatic new_loc();
    rif.loc_req   = 1'b1;
    rif.loc_we    = 1'($urandom_range(0, 1));
    rif.loc_addr  = 16'($urandom);
    rif.loc_wdata = $urandom;
  endtask

  task automatic drive_random();
    rif.spi_addr_rdy  = ($urandom_range(0, 9) == 0);
    rif.spi_rd        = 1'($urandom_range(0, 1));
    rif.spi_addr      = 16'($urandom);
    rif.spi_wdata_rdy = ($urandom_range(0, 11) == 0);
    rif.spi_wdata     = $urandom;
    if (rif.loc_ack) begin
      if ($urandom_range(0, 1) == 1) new_loc();
      else rif.loc_req = 1'b0;
    end else if (!rif.loc_req && $urandom_range(0, 5) == 0) begin
      new_loc();
    end
    rif.bus_ack   = 1'b0;
    rif.bus_rdata = $urandom;
    if (rif.bus_req) begin
      if (ack_wait < 0) ack_wait = (TO_EN && $urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 4);
      if (ack_wait == 0) begin
        rif.bus_ack = 1'b1;
        ack_wait    = -1;
      end else begin
        ack_wait--;
      end
    end else begin
      ack_wait    = -1;
      rif.bus_ack = ($urandom_range(0, 15) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    init_inputs();
    repeat (3) @(negedge clk_100m);
    chk_en = 1'b1;
    check("rst dbg_state", 32'(dbg_state), 32'h0);
    check("rst bus_req", 32'(rif.bus_req), 32'h0);
    check("rst spi_rdata", rif.spi_rdata, 32'h0);
    rst_n_syn = 1'b1;
    repeat (2) @(negedge clk_100m);

    // SPI read on an idle bus, acked three cycles after the request
    rif.spi_addr_rdy = 1'b1; rif.spi_rd = 1'b1; rif.spi_addr = 16'h0010;
    @(negedge clk_100m); idle_pulses();
    check("rd bus_req", 32'(rif.bus_req), 32'h1);
    check("rd bus_addr", 32'(rif.bus_addr), 32'h0010);
    check("rd bus_we", 32'(rif.bus_we), 32'h0);
    repeat (2) @(negedge clk_100m);
    rif.bus_ack = 1'b1; rif.bus_rdata = 32'h1234_5678;
    @(negedge clk_100m); idle_pulses();
    check("rd done bus_req", 32'(rif.bus_req), 32'h0);
    check("rd done bus_we", 32'(rif.bus_we), 32'h0);
    check("rd spi_rdata", rif.spi_rdata, 32'h1234_5678);
    repeat (2) @(negedge clk_100m);

    // Local write and SPI read arrive together: SPI first, one idle cycle, then local
    rif.loc_req = 1'b1; rif.loc_we = 1'b1; rif.loc_addr = 16'h0020; rif.loc_wdata = 32'hA5A5_A5A5;
    rif.spi_addr_rdy = 1'b1; rif.spi_rd = 1'b1; rif.spi_addr = 16'h0030;
    @(negedge clk_100m); idle_pulses();
    check("pri first addr", 32'(rif.bus_addr), 32'h0030);
    check("pri first we", 32'(rif.bus_we), 32'h0);
    rif.bus_ack = 1'b1; rif.bus_rdata = 32'h0BAD_F00D;
    @(negedge clk_100m); idle_pulses();
    check("pri gap bus_req", 32'(rif.bus_req), 32'h0);
    check("pri spi_rdata", rif.spi_rdata, 32'h0BAD_F00D);
    @(negedge clk_100m);
    check("pri loc bus_req", 32'(rif.bus_req), 32'h1);
    check("pri loc bus_we", 32'(rif.bus_we), 32'h1);
    check("pri loc addr", 32'(rif.bus_addr), 32'h0020);
    check("pri loc wdata", rif.bus_wdata, 32'hA5A5_A5A5);
    rif.bus_ack = 1'b1;
    @(negedge clk_100m); idle_pulses();
    check("pri loc_ack", 32'(rif.loc_ack), 32'h1);
    rif.loc_req = 1'b0;
    @(negedge clk_100m);
    check("pri loc_ack once", 32'(rif.loc_ack), 32'h0);
    repeat (2) @(negedge clk_100m);

    // SPI write traffic during a local read: no preemption, overrun flagged, last data wins
    rif.loc_req = 1'b1; rif.loc_we = 1'b0; rif.loc_addr = 16'h0040;
    @(negedge clk_100m);
    check("nopre loc addr", 32'(rif.bus_addr), 32'h0040);
    rif.spi_addr_rdy = 1'b1; rif.spi_rd = 1'b0; rif.spi_addr = 16'h0050;
    @(negedge clk_100m); idle_pulses();
    rif.spi_wdata_rdy = 1'b1; rif.spi_wdata = 32'h1111_1111;
    @(negedge clk_100m);
    rif.spi_wdata_rdy = 1'b1; rif.spi_wdata = 32'h2222_2222;
    @(negedge clk_100m); idle_pulses();
    check("ovr arb_err", 32'(rif.arb_err), 32'h1);
    check("nopre still loc", 32'(rif.bus_addr), 32'h0040);
    @(negedge clk_100m);
    check("ovr arb_err once", 32'(rif.arb_err), 32'h0);
    rif.bus_ack = 1'b1; rif.bus_rdata = 32'hCAFE_0001;
    @(negedge clk_100m); idle_pulses();
    check("nopre loc_ack", 32'(rif.loc_ack), 32'h1);
    check("nopre loc_rdata", rif.loc_rdata, 32'hCAFE_0001);
    rif.loc_req = 1'b0;
    @(negedge clk_100m);
    check("wr bus_we", 32'(rif.bus_we), 32'h1);
    check("wr bus_addr", 32'(rif.bus_addr), 32'h0050);
    check("wr bus_wdata", rif.bus_wdata, 32'h2222_2222);
    rif.bus_ack = 1'b1;
    @(negedge clk_100m); idle_pulses();
    check("wr done bus_req", 32'(rif.bus_req), 32'h0);
    repeat (2) @(negedge clk_100m);

    // SPI read with no bus_ack
    rif.spi_addr_rdy = 1'b1; rif.spi_rd = 1'b1; rif.spi_addr = 16'h0060;
    @(negedge clk_100m); idle_pulses();
    if (TO_EN) begin
      repeat (TIMEOUT_CYC - 1) @(negedge clk_100m);
      check("to last req cycle", 32'(rif.bus_req), 32'h1);
      @(negedge clk_100m);
      check("to bus_req drop", 32'(rif.bus_req), 32'h0);
      check("to spi_rdata", rif.spi_rdata, 32'hDEAD_BEEF);
      check("to arb_err", 32'(rif.arb_err), 32'h1);
    end else begin
      repeat (40) @(negedge clk_100m);
      check("noto bus_req held", 32'(rif.bus_req), 32'h1);
      check("noto arb_err", 32'(rif.arb_err), 32'h0);
      rif.bus_ack = 1'b1; rif.bus_rdata = 32'h5555_AAAA;
      @(negedge clk_100m); idle_pulses();
      check("noto bus_req drop", 32'(rif.bus_req), 32'h0);
      check("noto spi_rdata", rif.spi_rdata, 32'h5555_AAAA);
    end
    repeat (2) @(negedge clk_100m);

    // Reset in the middle of an SPI read with a write pending
    rif.spi_addr_rdy = 1'b1; rif.spi_rd = 1'b1; rif.spi_addr = 16'h0070;
    @(negedge clk_100m); idle_pulses();
    check("mid rst grant", 32'(rif.bus_req), 32'h1);
    rif.spi_wdata_rdy = 1'b1; rif.spi_wdata = 32'h3333_3333;
    @(negedge clk_100m); idle_pulses();
    #2 rst_n_syn = 1'b0;
    #1;
    check("arst bus_req", 32'(rif.bus_req), 32'h0);
    check("arst bus_addr", 32'(rif.bus_addr), 32'h0);
    check("arst spi_rdata", rif.spi_rdata, 32'h0);
    check("arst loc_rdata", rif.loc_rdata, 32'h0);
    check("arst dbg_state", 32'(dbg_state), 32'h0);
    repeat (2) @(negedge clk_100m);
    rst_n_syn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_100m);
      check("post rst no grant", 32'(rif.bus_req), 32'h0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_100m);
      drive_random();
    end
    @(negedge clk_100m);
    idle_pulses();
    rif.loc_req = 1'b0;
    @(negedge clk_100m);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
